// File: rtl/shared_data_mem.sv
// shared_data_mem: single-port data memory shared by CORE_COUNT cores.
// A round-robin arbiter grants one core per cycle. The grant is combinational
// (ack) and the access happens at the following rising edge. Read data comes
// back one cycle later on that core's own dataOut slice, together with a
// one-cycle rdValid pulse.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   req      per-core access request (bit i = core i)
//   wrEn     per-core write enable, 1=write 0=read, qualified by req
//   address  per-core address, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   dataIn   per-core write data, core i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack      combinational one-hot grant
//   rdValid  registered one-hot read-return strobe
//   dataOut  per-core registered read data, core i at [i*DATA_WIDTH +: DATA_WIDTH]
module shared_data_mem #(
  parameter int CORE_COUNT = 4,
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CORE_COUNT-1:0]            req,
  input  logic [CORE_COUNT-1:0]            wrEn,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] address,
  input  logic [CORE_COUNT*DATA_WIDTH-1:0] dataIn,
  output logic [CORE_COUNT-1:0]            ack,
  output logic [CORE_COUNT-1:0]            rdValid,
  output logic [CORE_COUNT*DATA_WIDTH-1:0] dataOut
);

  localparam int PTR_WIDTH = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

  logic [PTR_WIDTH-1:0]             pointer;
  logic [PTR_WIDTH-1:0]             grantIdx;
  logic                             found;
  logic                             grantValid;
  logic                             selWr;
  logic [ADDR_WIDTH-1:0]            selAddr;
  logic [DATA_WIDTH-1:0]            selData;
  logic                             inRange;
  logic                             memWe;
  logic                             memRe;
  logic [DATA_WIDTH-1:0]            mem [DEPTH];
  logic [DATA_WIDTH-1:0]            rdWord;
  logic                             rdInRange;
  logic [DATA_WIDTH-1:0]            freshWord;
  logic [CORE_COUNT*DATA_WIDTH-1:0] heldOut;

  // Round-robin search: the first pass covers cores at or above the pointer,
  // the second pass wraps around to the cores below it. The winning core's
  // channel is steered onto the single memory port. Reset forces ack low so
  // an edge that coincides with reset never performs an access.
  always_comb begin
    ack      = '0;
    grantIdx = '0;
    found    = 1'b0;
    selWr    = 1'b0;
    selAddr  = '0;
    selData  = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (!found && req[k] && (k >= int'(pointer))) begin
        found    = 1'b1;
        ack[k]   = 1'b1;
        grantIdx = PTR_WIDTH'(k);
        selWr    = wrEn[k];
        selAddr  = address[k*ADDR_WIDTH +: ADDR_WIDTH];
        selData  = dataIn[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (!found && req[k] && (k < int'(pointer))) begin
        found    = 1'b1;
        ack[k]   = 1'b1;
        grantIdx = PTR_WIDTH'(k);
        selWr    = wrEn[k];
        selAddr  = address[k*ADDR_WIDTH +: ADDR_WIDTH];
        selData  = dataIn[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (rst) begin
      ack = '0;
    end
  end

  // Addresses at or beyond DEPTH are still granted, but their writes are
  // dropped and their reads return zero.
  always_comb begin
    grantValid = |ack;
    inRange    = int'(selAddr) < DEPTH;
    memWe      = grantValid && selWr && inRange;
    memRe      = grantValid && !selWr;
  end

  // Plain synchronous single-port RAM with a registered read word and no
  // reset, so it maps onto block RAM. Whatever an out-of-range read fetches
  // here is masked off downstream.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[selAddr] <= selData;
    end
    if (memRe) begin
      rdWord <= mem[selAddr];
    end
  end

  // Control state: the round-robin pointer moves to the core just after the
  // winner, rdValid marks which core the RAM word belongs to, and heldOut
  // keeps each core's last returned word once its rdValid cycle has passed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pointer   <= '0;
      rdValid   <= '0;
      rdInRange <= 1'b0;
      heldOut   <= '0;
    end else begin
      for (int k = 0; k < CORE_COUNT; k++) begin
        if (rdValid[k]) begin
          heldOut[k*DATA_WIDTH +: DATA_WIDTH] <= freshWord;
        end
      end
      rdValid   <= memRe ? ack : '0;
      rdInRange <= inRange;
      if (grantValid) begin
        pointer <= (grantIdx == PTR_WIDTH'(CORE_COUNT - 1)) ? '0 : grantIdx + 1'b1;
      end
    end
  end

  // During the rdValid cycle the owning slice shows the fresh RAM word
  // directly. Every other slice shows its held copy. Both sources are
  // registers, so dataOut only changes at clock edges or on reset.
  always_comb begin
    freshWord = rdInRange ? rdWord : '0;
    dataOut   = heldOut;
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (rdValid[k]) begin
        dataOut[k*DATA_WIDTH +: DATA_WIDTH] = freshWord;
      end
    end
  end

endmodule
